ring_node_mp: RTL and testbench

RING_NODE_MP -- requirements
Module: ring_node_mp

---
 rtl/md_pkg.sv | 43 ++++
 rtl/pe_inj_fifo.sv | 55 +++++
 rtl/ring_node_mp.sv | 167 ++++++++++++++++
 tb/tb_ring_node_mp.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared molecular-dynamics ring types plus the round-robin helpers used by
// the ring nodes.
package md_pkg;

  localparam int MD_DATA_WIDTH        = 32;
  localparam int MD_PARTICLE_ID_WIDTH = 7;
  localparam int MD_NODE_ID_WIDTH     = 6;
  localparam int MAX_PE               = 8;
  localparam int PE_IDX_W             = 3;

  typedef struct packed {
    logic [MD_PARTICLE_ID_WIDTH-1:0] particle_id;
    logic [MD_DATA_WIDTH-1:0]        force_x;
    logic [MD_DATA_WIDTH-1:0]        force_y;
    logic [MD_DATA_WIDTH-1:0]        force_z;
  } force_data_t;

  typedef struct packed {
    logic [MD_NODE_ID_WIDTH-1:0] dest_id;
    force_data_t                 payload;
  } packet_t;

  // Returns {found, index}: first set bit of req at or after start, wrapping modulo n.
  function automatic logic [PE_IDX_W:0] rr_pick(input logic [MAX_PE-1:0]   req,
                                                input logic [PE_IDX_W-1:0] start,
                                                input int                  n);
    logic [PE_IDX_W:0] res;
    int                idx;
    res = '0;
    for (int k = 0; k < MAX_PE; k++) begin
      idx = int'(start) + k;
      if (idx >= n) idx = idx - n;
      if (k < n && !res[PE_IDX_W] && req[idx]) res = {1'b1, PE_IDX_W'(idx)};
    end
    return res;
  endfunction

  function automatic logic [PE_IDX_W-1:0] rr_next(input logic [PE_IDX_W-1:0] idx,
                                                  input int                  n);
    return (int'(idx) == n - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/pe_inj_fifo.sv
// Small injection FIFO with combinational head read; push and pop may share an
// edge at any occupancy, including full.
module pe_inj_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_en, pop_en;

  always_comb begin
    pop_en   = pop & (count_q != '0);
    push_en  = push & ((count_q != (PTR_W+1)'(DEPTH)) | pop_en);
    wr_ptr_d = push_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + (PTR_W+1)'(push_en) - (PTR_W+1)'(pop_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_en) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/ring_node_mp.sv
// Ring node with NUM_PE local injection ports; the ring has absolute priority,
// and free outputs are shared round-robin among FIFO heads.
module ring_node_mp
  import md_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int NODE_ID_WIDTH     = 6,
  parameter int HOME_CELL_ID      = 0,
  parameter int NUM_PE            = 2,
  parameter int FIFO_DEPTH        = 4,
  parameter int STARVE_LIMIT      = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  packet_t [NUM_PE-1:0]    pe_pkt_in,
  input  logic    [NUM_PE-1:0]    pe_pkt_valid,
  output logic    [NUM_PE-1:0]    pe_ready,
  input  packet_t                 prev_pkt_in,
  input  logic                    prev_pkt_valid,
  output force_data_t             fc_data_out,
  output logic                    fc_data_valid,
  output packet_t                 nxt_pkt_out,
  output logic                    nxt_pkt_valid,
  output logic    [NUM_PE-1:0]    pe_starved
);

  localparam int PKT_W = NODE_ID_WIDTH + PARTICLE_ID_WIDTH + 3 * DATA_WIDTH;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int BLK_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [NODE_ID_WIDTH-1:0] HOME_ID = NODE_ID_WIDTH'(HOME_CELL_ID);

  packet_t              head_pkt [NUM_PE];
  logic [CNT_W-1:0]     count    [NUM_PE];
  logic [NUM_PE-1:0]    push, pop, full, empty;
  logic [NUM_PE-1:0]    head_local, head_fwd;
  logic                 net_local, net_fwd;
  logic [MAX_PE-1:0]    fc_req, nxt_req;
  logic [PE_IDX_W:0]    fc_pick, nxt_pick;
  logic                 fc_gnt, nxt_gnt;
  logic [PE_IDX_W-1:0]  fc_idx, nxt_idx;
  packet_t              fc_head, nxt_head;

  force_data_t          fc_data_q, fc_data_d;
  logic                 fc_valid_q, fc_valid_d;
  packet_t              nxt_pkt_q, nxt_pkt_d;
  logic                 nxt_valid_q, nxt_valid_d;
  logic [PE_IDX_W-1:0]  rr_fc_q, rr_fc_d;
  logic [PE_IDX_W-1:0]  rr_nxt_q, rr_nxt_d;

  assign net_local = prev_pkt_valid && (prev_pkt_in.dest_id == HOME_ID);
  assign net_fwd   = prev_pkt_valid && (prev_pkt_in.dest_id != HOME_ID);

  for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_pe
    logic [BLK_W-1:0] blk_q, blk_d;

    pe_inj_fifo #(
      .WIDTH (PKT_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[gi]),
      .push_data (pe_pkt_in[gi]),
      .pop       (pop[gi]),
      .pop_data  (head_pkt[gi]),
      .full      (full[gi]),
      .empty     (empty[gi]),
      .count     (count[gi])
    );

    assign pe_ready[gi]   = ~full[gi];
    assign push[gi]       = pe_pkt_valid[gi] & ~full[gi];
    assign head_local[gi] = ~empty[gi] & (head_pkt[gi].dest_id == HOME_ID);
    assign head_fwd[gi]   = ~empty[gi] & (head_pkt[gi].dest_id != HOME_ID);
    // A head can only request one output, so at most one of these terms fires.
    assign pop[gi] = (fc_gnt && fc_idx == PE_IDX_W'(gi)) ||
                     (nxt_gnt && nxt_idx == PE_IDX_W'(gi));

    always_comb begin
      blk_d = blk_q;
      if (count[gi] == '0 || pop[gi]) blk_d = '0;
      else if (blk_q != BLK_W'(STARVE_LIMIT)) blk_d = blk_q + 1'b1;
    end

    always_ff @(posedge clk) begin
      if (rst) blk_q <= '0;
      else     blk_q <= blk_d;
    end

    assign pe_starved[gi] = (blk_q == BLK_W'(STARVE_LIMIT));
  end

  always_comb begin
    fc_req  = '0;
    nxt_req = '0;
    if (!net_local) fc_req[NUM_PE-1:0]  = head_local;
    if (!net_fwd)   nxt_req[NUM_PE-1:0] = head_fwd;
  end

  assign fc_pick  = rr_pick(fc_req, rr_fc_q, NUM_PE);
  assign nxt_pick = rr_pick(nxt_req, rr_nxt_q, NUM_PE);
  assign fc_gnt   = fc_pick[PE_IDX_W];
  assign nxt_gnt  = nxt_pick[PE_IDX_W];
  assign fc_idx   = fc_pick[PE_IDX_W-1:0];
  assign nxt_idx  = nxt_pick[PE_IDX_W-1:0];

  always_comb begin
    fc_head  = '0;
    nxt_head = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (fc_idx == PE_IDX_W'(i))  fc_head  = head_pkt[i];
      if (nxt_idx == PE_IDX_W'(i)) nxt_head = head_pkt[i];
    end
  end

  always_comb begin
    fc_data_d   = '0;
    fc_valid_d  = 1'b0;
    nxt_pkt_d   = '0;
    nxt_valid_d = 1'b0;
    rr_fc_d     = rr_fc_q;
    rr_nxt_d    = rr_nxt_q;

    if (net_local) begin
      fc_data_d  = prev_pkt_in.payload;
      fc_valid_d = 1'b1;
    end else if (fc_gnt) begin
      fc_data_d  = fc_head.payload;
      fc_valid_d = 1'b1;
      rr_fc_d    = rr_next(fc_idx, NUM_PE);
    end

    if (net_fwd) begin
      nxt_pkt_d   = prev_pkt_in;
      nxt_valid_d = 1'b1;
    end else if (nxt_gnt) begin
      nxt_pkt_d   = nxt_head;
      nxt_valid_d = 1'b1;
      rr_nxt_d    = rr_next(nxt_idx, NUM_PE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fc_data_q   <= '0;
      fc_valid_q  <= 1'b0;
      nxt_pkt_q   <= '0;
      nxt_valid_q <= 1'b0;
      rr_fc_q     <= '0;
      rr_nxt_q    <= '0;
    end else begin
      fc_data_q   <= fc_data_d;
      fc_valid_q  <= fc_valid_d;
      nxt_pkt_q   <= nxt_pkt_d;
      nxt_valid_q <= nxt_valid_d;
      rr_fc_q     <= rr_fc_d;
      rr_nxt_q    <= rr_nxt_d;
    end
  end

  assign fc_data_out   = fc_data_q;
  assign fc_data_valid = fc_valid_q;
  assign nxt_pkt_out   = nxt_pkt_q;
  assign nxt_pkt_valid = nxt_valid_q;

endmodule

// File: tb/tb_ring_node_mp.sv
// Directed and random checks of ring_node_mp against a queue-based reference
// model, plus a direct check of the injection FIFO at full occupancy.
module tb_ring_node_mp;
  import md_pkg::*;

  localparam logic [5:0] HOME = 6'd5;
  localparam logic [5:0] FWD  = 6'd9;

  logic                clk;
  logic                rst;
  packet_t [1:0]       pe_pkt_in;
  logic    [1:0]       pe_pkt_valid;
  logic    [1:0]       pe_ready;
  packet_t             prev_pkt_in;
  logic                prev_pkt_valid;
  force_data_t         fc_data_out;
  logic                fc_data_valid;
  packet_t             nxt_pkt_out;
  logic                nxt_pkt_valid;
  logic    [1:0]       pe_starved;

  logic                f_rst, f_push, f_pop, f_full, f_empty;
  logic    [7:0]       f_din, f_dout;
  logic    [2:0]       f_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  ring_node_mp #(
    .DATA_WIDTH(32), .PARTICLE_ID_WIDTH(7), .NODE_ID_WIDTH(6), .HOME_CELL_ID(5),
    .NUM_PE(2), .FIFO_DEPTH(4), .STARVE_LIMIT(3)
  ) dut (
    .clk(clk), .rst(rst), .pe_pkt_in(pe_pkt_in), .pe_pkt_valid(pe_pkt_valid),
    .pe_ready(pe_ready), .prev_pkt_in(prev_pkt_in), .prev_pkt_valid(prev_pkt_valid),
    .fc_data_out(fc_data_out), .fc_data_valid(fc_data_valid), .nxt_pkt_out(nxt_pkt_out),
    .nxt_pkt_valid(nxt_pkt_valid), .pe_starved(pe_starved)
  );

  pe_inj_fifo #(.WIDTH(8), .DEPTH(4)) u_fifo (
    .clk(clk), .rst(f_rst), .push(f_push), .push_data(f_din), .pop(f_pop),
    .pop_data(f_dout), .full(f_full), .empty(f_empty), .count(f_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one queue per port, last winner per output, blocked counts.
  packet_t     mq [2][$];
  int          last_fc, last_nxt;
  int          blk [2];
  bit          e_acc [2];
  force_data_t e_fc;
  logic        e_fc_v;
  packet_t     e_nxt;
  logic        e_nxt_v;

  function automatic packet_t mk(input logic [5:0] dest, input logic [6:0] pid);
    packet_t p;
    p.dest_id             = dest;
    p.payload.particle_id = pid;
    p.payload.force_x     = $urandom;
    p.payload.force_y     = $urandom;
    p.payload.force_z     = $urandom;
    return p;
  endfunction

  function automatic void model_tick();
    int fcw, nw, sz [2];
    bit popd [2];
    e_fc = '0; e_fc_v = 1'b0; e_nxt = '0; e_nxt_v = 1'b0;
    e_acc[0] = 1'b0; e_acc[1] = 1'b0;
    if (rst) begin
      mq[0].delete(); mq[1].delete();
      last_fc = 1; last_nxt = 1; blk[0] = 0; blk[1] = 0;
      return;
    end
    fcw = -1; nw = -1;
    for (int i = 0; i < 2; i++) begin sz[i] = mq[i].size(); popd[i] = 1'b0; end
    if (prev_pkt_valid && prev_pkt_in.dest_id == HOME) begin
      e_fc_v = 1'b1; e_fc = prev_pkt_in.payload;
    end else begin
      for (int k = 1; k <= 2; k++) begin
        int i;
        i = (last_fc + k) % 2;
        if (fcw < 0 && sz[i] > 0 && mq[i][0].dest_id == HOME) fcw = i;
      end
    end
    if (prev_pkt_valid && prev_pkt_in.dest_id != HOME) begin
      e_nxt_v = 1'b1; e_nxt = prev_pkt_in;
    end else begin
      for (int k = 1; k <= 2; k++) begin
        int i;
        i = (last_nxt + k) % 2;
        if (nw < 0 && sz[i] > 0 && mq[i][0].dest_id != HOME) nw = i;
      end
    end
    if (fcw >= 0) begin e_fc_v = 1'b1; e_fc = mq[fcw][0].payload; last_fc = fcw; popd[fcw] = 1'b1; end
    if (nw >= 0) begin e_nxt_v = 1'b1; e_nxt = mq[nw][0]; last_nxt = nw; popd[nw] = 1'b1; end
    for (int i = 0; i < 2; i++) begin
      if (sz[i] == 0 || popd[i]) blk[i] = 0;
      else if (blk[i] < 3) blk[i] = blk[i] + 1;
      if (popd[i]) void'(mq[i].pop_front());
      if (pe_pkt_valid[i] && sz[i] < 4) begin mq[i].push_back(pe_pkt_in[i]); e_acc[i] = 1'b1; end
    end
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("fc_valid", 128'(fc_data_valid), 128'(e_fc_v));
    chk("fc_data", 128'(fc_data_out), 128'(e_fc));
    chk("nxt_valid", 128'(nxt_pkt_valid), 128'(e_nxt_v));
    chk("nxt_pkt", 128'(nxt_pkt_out), 128'(e_nxt));
    chk("pe_ready", 128'(pe_ready), 128'({mq[1].size() < 4, mq[0].size() < 4}));
    chk("pe_starved", 128'(pe_starved), 128'({blk[1] == 3, blk[0] == 3}));
  endtask

  task automatic step();
    model_tick();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic fstep();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pe_pkt_valid = '0; pe_pkt_in = '0; prev_pkt_valid = 1'b0; prev_pkt_in = '0;
  endtask

  packet_t pa, pb, pk [5];
  int      k, ord;
  logic    exp_src;

  initial begin
    idle();
    rst = 1'b1; f_rst = 1'b1; f_push = 1'b0; f_pop = 1'b0; f_din = '0;
    #2;
    step(); step();
    chk("rst_ready", 128'(pe_ready), 128'(2'b11));
    chk("rst_fc_v", 128'(fc_data_valid), 128'(0));
    rst = 1'b0;
    step();

    // Network only: local then forward, one cycle each.
    pa = mk(HOME, 7'd1); prev_pkt_in = pa; prev_pkt_valid = 1'b1;
    step();
    chk("net_fc_payload", 128'(fc_data_out), 128'(pa.payload));
    chk("net_fc_only", 128'({fc_data_valid, nxt_pkt_valid}), 128'(2'b10));
    pb = mk(FWD, 7'd2); prev_pkt_in = pb;
    step();
    chk("net_nxt_pkt", 128'(nxt_pkt_out), 128'(pb));
    chk("net_nxt_only", 128'({fc_data_valid, nxt_pkt_valid}), 128'(2'b01));
    idle();
    step();

    // Dual output: PE0 local and PE1 forward in the same cycle.
    pa = mk(HOME, 7'd10); pb = mk(FWD, 7'd11);
    pe_pkt_in[0] = pa; pe_pkt_in[1] = pb; pe_pkt_valid = 2'b11;
    step();
    chk("dual_no_bypass", 128'({fc_data_valid, nxt_pkt_valid}), 128'(2'b00));
    idle();
    step();
    chk("dual_fc", 128'(fc_data_out), 128'(pa.payload));
    chk("dual_nxt", 128'(nxt_pkt_out), 128'(pb));

    // Round-robin: both ports stream forward traffic.
    exp_src = 1'b0;
    for (int c = 0; c < 12; c++) begin
      pe_pkt_in[0] = mk(FWD, 7'h10 + 7'(c));
      pe_pkt_in[1] = mk(FWD, 7'h40 + 7'(c));
      pe_pkt_valid = 2'b11;
      step();
      if (nxt_pkt_valid) begin
        chk("rr_alternate", 128'(nxt_pkt_out.payload.particle_id[6]), 128'(exp_src));
        exp_src = ~exp_src;
      end
      chk("rr_no_starve", 128'(pe_starved), 128'(2'b00));
    end
    idle();
    repeat (10) step();

    // Full FIFO under network backpressure, then drain.
    for (int i = 0; i < 5; i++) pk[i] = mk(FWD, 7'h20 + 7'(i));
    k = 0;
    for (int c = 0; c < 10; c++) begin
      prev_pkt_in = mk(FWD, 7'h60 + 7'(c)); prev_pkt_valid = 1'b1;
      pe_pkt_in[0] = pk[k < 5 ? k : 4]; pe_pkt_valid[0] = (k < 5);
      step();
      if (e_acc[0]) k++;
    end
    chk("bp_ready_low", 128'(pe_ready[0]), 128'(0));
    chk("bp_starved", 128'(pe_starved[0]), 128'(1));
    prev_pkt_valid = 1'b0; prev_pkt_in = '0;
    ord = 0;
    for (int c = 0; c < 8; c++) begin
      pe_pkt_in[0] = pk[k < 5 ? k : 4]; pe_pkt_valid[0] = (k < 5);
      step();
      if (e_acc[0]) k++;
      if (nxt_pkt_valid && ord < 5) begin
        chk("drain_order", 128'(nxt_pkt_out), 128'(pk[ord]));
        ord++;
      end
    end
    chk("drain_count", 128'(ord), 128'(5));
    chk("drain_starve_clear", 128'(pe_starved), 128'(2'b00));
    idle();

    // Reset with three entries held in each FIFO.
    for (int c = 0; c < 3; c++) begin
      prev_pkt_in = mk(FWD, 7'h70); prev_pkt_valid = 1'b1;
      pe_pkt_in[0] = mk(FWD, 7'h30 + 7'(c)); pe_pkt_in[1] = mk(FWD, 7'h50 + 7'(c));
      pe_pkt_valid = 2'b11;
      step();
    end
    pe_pkt_valid = 2'b00;
    step();
    rst = 1'b1; pe_pkt_valid = 2'b11;
    step();
    chk("mid_rst_outs", 128'({fc_data_valid, nxt_pkt_valid, pe_starved}), 128'(0));
    chk("mid_rst_data", 128'({fc_data_out, nxt_pkt_out}), 128'(0));
    chk("mid_rst_ready", 128'(pe_ready), 128'(2'b11));
    rst = 1'b0; idle();
    repeat (4) begin
      step();
      chk("no_stale", 128'({fc_data_valid, nxt_pkt_valid}), 128'(2'b00));
    end

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      logic [5:0] d;
      rst = ($urandom_range(0, 120) == 0);
      for (int i = 0; i < 2; i++) begin
        case ($urandom_range(0, 3))
          0, 1:    d = HOME;
          2:       d = FWD;
          default: d = 6'($urandom);
        endcase
        pe_pkt_in[i]    = mk(d, 7'($urandom));
        pe_pkt_valid[i] = ($urandom_range(0, 2) != 0);
      end
      d = ($urandom_range(0, 1) == 0) ? HOME : 6'($urandom);
      prev_pkt_in    = mk(d, 7'($urandom));
      prev_pkt_valid = ($urandom_range(0, 2) == 0);
      step();
    end
    rst = 1'b0; idle();

    // Injection FIFO: push and pop together while full.
    f_rst = 1'b1; fstep(); f_rst = 1'b0;
    for (int v = 0; v < 4; v++) begin
      f_din = 8'h10 + 8'(v); f_push = 1'b1; fstep();
    end
    f_push = 1'b0;
    chk("fifo_full", 128'({f_full, f_cnt}), 128'({1'b1, 3'd4}));
    for (int v = 0; v < 2; v++) begin
      f_din = 8'h14 + 8'(v); f_push = 1'b1; f_pop = 1'b1;
      chk("fifo_head_pp", 128'(f_dout), 128'(8'h10 + 8'(v)));
      fstep();
      chk("fifo_pp_count", 128'({f_full, f_cnt}), 128'({1'b1, 3'd4}));
    end
    f_push = 1'b0;
    for (int v = 2; v < 6; v++) begin
      f_pop = 1'b1;
      chk("fifo_order", 128'(f_dout), 128'(8'h10 + 8'(v)));
      fstep();
    end
    f_pop = 1'b0;
    chk("fifo_empty", 128'({f_empty, f_cnt}), 128'({1'b1, 3'd0}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
